// File: rtl/alu_flag_unit.sv
// NZCV status register with ARM condition-code evaluation, a one-deep shadow
// copy for exception entry/exit, and a registered condition-pass result.
module alu_flag_unit #(
    parameter logic BYPASS  = 1'b1,
    parameter logic NV_PASS = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_we,
    input  logic [3:0] flag_mask,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    input  logic       stall,
    input  logic       flush,
    input  logic       save_req,
    input  logic       restore_req,
    output logic [3:0] nzcv,
    output logic       carry_to_alu,
    output logic       cond_pass,
    output logic       cond_out_valid
);

    logic [3:0] shadow;
    logic [3:0] alu_flags;
    logic [3:0] nzcv_next;
    logic [3:0] eval_flags;
    logic       eval_pass;

    function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] cc);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c & !z;
            4'h9:    r = !c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = NV_PASS;
        endcase
        return r;
    endfunction

    assign alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};

    // Restore outranks a flag write arriving in the same cycle.
    always_comb begin
        nzcv_next = nzcv;
        if (restore_req) begin
            nzcv_next = shadow;
        end else if (flag_we) begin
            nzcv_next = (alu_flags & flag_mask) | (nzcv & ~flag_mask);
        end
    end

    assign eval_flags   = (BYPASS && (flag_we || restore_req)) ? nzcv_next : nzcv;
    assign eval_pass    = cond_eval(eval_flags, cond_code);
    // Deliberately taken from the register, never the bypass path.
    assign carry_to_alu = nzcv[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            nzcv           <= 4'b0000;
            shadow         <= 4'b0000;
            cond_pass      <= 1'b0;
            cond_out_valid <= 1'b0;
        end else if (!stall) begin
            nzcv           <= nzcv_next;
            if (save_req) begin
                shadow <= nzcv;
            end
            cond_out_valid <= cond_valid & !flush;
            cond_pass      <= cond_valid & !flush & eval_pass;
        end
    end

endmodule
